// File: rtl/miriscv_lsu_if.sv
// miriscv data-memory bus between the LSU and data memory.
// Request/grant/response handshake with word address and byte enables.
interface miriscv_lsu_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o,
    output data_we_o,
    output data_be_o,
    output data_addr_o,
    output data_wdata_o,
    input  data_gnt_i,
    input  data_rvalid_i,
    input  data_rdata_i
  );

  modport slave (
    input  data_req_o,
    input  data_we_o,
    input  data_be_o,
    input  data_addr_o,
    input  data_wdata_o,
    output data_gnt_i,
    output data_rvalid_i,
    output data_rdata_i
  );
endinterface

// File: rtl/miriscv_lsu.sv
// miriscv load-store unit: one bus transaction per memory
// instruction, stalling the core until the response returns.
module miriscv_lsu (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         lsu_req_i,
  input  logic         lsu_we_i,
  input  logic [2:0]   lsu_size_i,
  input  logic [31:0]  lsu_addr_i,
  input  logic [31:0]  lsu_data_i,
  output logic [31:0]  lsu_data_o,
  output logic         lsu_stall_req_o,
  output logic         lsu_err_o,
  miriscv_lsu_if.master bus
);

  localparam logic [2:0] SzByte  = 3'd0;
  localparam logic [2:0] SzHalf  = 3'd1;
  localparam logic [2:0] SzWord  = 3'd2;
  localparam logic [2:0] SzUByte = 3'd4;
  localparam logic [2:0] SzUHalf = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  state_t      stateNext;

  logic [1:0]  off;
  logic        legal;
  logic [3:0]  beNew;
  logic [31:0] wdataNew;

  logic        weQ;
  logic [3:0]  beQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic [2:0]  sizeQ;
  logic [1:0]  offQ;
  logic [31:0] loadQ;

  logic [31:0] laneWord;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [31:0] loadVal;
  logic        capture;

  assign off = lsu_addr_i[1:0];

  always_comb begin
    legal    = 1'b0;
    beNew    = 4'b0000;
    wdataNew = lsu_data_i;
    case (lsu_size_i)
      SzByte, SzUByte: begin
        legal    = 1'b1;
        beNew    = 4'b0001 << off;
        wdataNew = {4{lsu_data_i[7:0]}};
      end
      SzHalf, SzUHalf: begin
        legal    = ~off[0];
        beNew    = 4'b0011 << {off[1], 1'b0};
        wdataNew = {2{lsu_data_i[15:0]}};
      end
      SzWord: begin
        legal    = (off == 2'b00);
        beNew    = 4'b1111;
        wdataNew = lsu_data_i;
      end
      default: legal = 1'b0;
    endcase
  end

  assign capture = (state == IDLE) & lsu_req_i & legal;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (capture) stateNext = REQ;
      REQ:  if (bus.data_gnt_i) stateNext = WAIT;
      WAIT: if (bus.data_rvalid_i) stateNext = DONE;
      DONE: stateNext = IDLE;
    endcase
  end

  // Lane selection always uses the offset captured with the request.
  assign laneWord = bus.data_rdata_i >> {offQ, 3'b000};
  assign byteLane = laneWord[7:0];
  assign halfLane = offQ[1] ? bus.data_rdata_i[31:16]
                            : bus.data_rdata_i[15:0];

  always_comb begin
    loadVal = bus.data_rdata_i;
    case (sizeQ)
      SzByte:  loadVal = {{24{byteLane[7]}}, byteLane};
      SzUByte: loadVal = {24'b0, byteLane};
      SzHalf:  loadVal = {{16{halfLane[15]}}, halfLane};
      SzUHalf: loadVal = {16'b0, halfLane};
      default: loadVal = bus.data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      weQ    <= 1'b0;
      beQ    <= 4'b0;
      addrQ  <= 32'b0;
      wdataQ <= 32'b0;
      sizeQ  <= 3'b0;
      offQ   <= 2'b0;
      loadQ  <= 32'b0;
    end else begin
      state <= stateNext;
      if (capture) begin
        weQ    <= lsu_we_i;
        beQ    <= beNew;
        addrQ  <= {lsu_addr_i[31:2], 2'b00};
        wdataQ <= wdataNew;
        sizeQ  <= lsu_size_i;
        offQ   <= off;
      end
      if ((state == WAIT) && bus.data_rvalid_i && !weQ)
        loadQ <= loadVal;
    end
  end

  assign bus.data_req_o   = (state == REQ);
  assign bus.data_we_o    = weQ;
  assign bus.data_be_o    = beQ;
  assign bus.data_addr_o  = addrQ;
  assign bus.data_wdata_o = wdataQ;

  assign lsu_data_o = loadQ;

  // DONE drops stall for one cycle so the core retires exactly once.
  assign lsu_stall_req_o = rstn_i & lsu_req_i & legal & (state != DONE);
  assign lsu_err_o = rstn_i & (state == IDLE) & lsu_req_i & ~legal;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed and randomized bench for miriscv_lsu against a
// byte-level reference model of alignment, lanes and extension.
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_err_o;

  miriscv_lsu_if bus ();

  miriscv_lsu dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_size_i      (lsu_size_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_data_o      (lsu_data_o),
    .lsu_stall_req_o (lsu_stall_req_o),
    .lsu_err_o       (lsu_err_o),
    .bus             (bus.master)
  );

  always #5 clk_i = ~clk_i;

  int nCmp = 0;
  int nBad = 0;
  logic [31:0] lastLoad = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nBytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit mLegal(input logic [2:0] sz,
                                input logic [31:0] a);
    int n = nBytes(sz);
    if (n == 0) return 0;
    return (int'(a[1:0]) % n) == 0;
  endfunction

  function automatic logic [3:0] mBe(input logic [2:0] sz,
                                     input logic [31:0] a);
    int n = nBytes(sz);
    int o = int'(a[1:0]);
    logic [3:0] be = '0;
    for (int k = 0; k < 4; k++)
      be[k] = (k >= o) && (k < o + n);
    return be;
  endfunction

  function automatic logic [31:0] mWdata(input logic [2:0] sz,
                                         input logic [31:0] d);
    int n = nBytes(sz);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] mLoad(input logic [2:0] sz,
                                        input logic [31:0] a,
                                        input logic [31:0] rd);
    int n = nBytes(sz);
    int o = int'(a[1:0]);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++)
      v[8*k +: 8] = rd[8*(o+k) +: 8];
    if ((sz == 3'd0 || sz == 3'd1) && v[8*n-1])
      for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  task automatic access(input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int gw,
                        input int rw, input bit noise);
    bit ok = mLegal(sz, a);
    logic [3:0] eBe;
    logic [31:0] eWd;
    int stalls = 0;
    @(posedge clk_i); #1;
    lsu_req_i  = 1'b1;
    lsu_we_i   = we;
    lsu_size_i = sz;
    lsu_addr_i = a;
    lsu_data_i = d;
    bus.data_gnt_i    = 1'b0;
    bus.data_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("idle_err", {31'b0, lsu_err_o}, {31'b0, !ok});
    chk("idle_req", {31'b0, bus.data_req_o}, 32'd0);
    if (!ok) begin
      chk("ill_stall", {31'b0, lsu_stall_req_o}, 32'd0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("ill_repulse", {31'b0, lsu_err_o}, 32'd1);
      chk("ill_req2", {31'b0, bus.data_req_o}, 32'd0);
      @(posedge clk_i); #1;
      lsu_req_i = 1'b0;
      @(negedge clk_i);
      chk("ill_err_off", {31'b0, lsu_err_o}, 32'd0);
      return;
    end
    eBe = mBe(sz, a);
    eWd = we ? mWdata(sz, d) : 32'h0;
    if (lsu_stall_req_o) stalls++;
    for (int i = 0; i <= gw; i++) begin
      @(posedge clk_i); #1;
      bus.data_gnt_i    = (i == gw);
      bus.data_rvalid_i = noise ? 1'($urandom) : 1'b0;
      bus.data_rdata_i  = $urandom;
      @(negedge clk_i);
      if (lsu_stall_req_o) stalls++;
      chk("req", {31'b0, bus.data_req_o}, 32'd1);
      chk("we", {31'b0, bus.data_we_o}, {31'b0, we});
      chk("be", {28'b0, bus.data_be_o}, {28'b0, eBe});
      chk("addr", bus.data_addr_o, {a[31:2], 2'b00});
      if (we) chk("wdata", bus.data_wdata_o, eWd);
    end
    for (int j = 0; j <= rw; j++) begin
      @(posedge clk_i); #1;
      bus.data_gnt_i    = noise ? 1'($urandom) : 1'b0;
      bus.data_rvalid_i = (j == rw);
      bus.data_rdata_i  = (j == rw) ? rd : $urandom;
      @(negedge clk_i);
      if (lsu_stall_req_o) stalls++;
      chk("wait_req", {31'b0, bus.data_req_o}, 32'd0);
    end
    if (!we) lastLoad = mLoad(sz, a, rd);
    @(posedge clk_i); #1;
    bus.data_gnt_i    = 1'b0;
    bus.data_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("done_stall", {31'b0, lsu_stall_req_o}, 32'd0);
    chk("done_data", lsu_data_o, lastLoad);
    chk("stall_cycles", stalls, 3 + gw + rw);
    @(posedge clk_i); #1;
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    chk("post_req", {31'b0, bus.data_req_o}, 32'd0);
    chk("post_data", lsu_data_o, lastLoad);
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_req"}, {31'b0, bus.data_req_o}, 32'd0);
    chk({tag, "_we"}, {31'b0, bus.data_we_o}, 32'd0);
    chk({tag, "_be"}, {28'b0, bus.data_be_o}, 32'd0);
    chk({tag, "_addr"}, bus.data_addr_o, 32'd0);
    chk({tag, "_wdata"}, bus.data_wdata_o, 32'd0);
    chk({tag, "_data"}, lsu_data_o, 32'd0);
    chk({tag, "_err"}, {31'b0, lsu_err_o}, 32'd0);
    chk({tag, "_stall"}, {31'b0, lsu_stall_req_o}, 32'd0);
  endtask

  initial begin
    rstn_i = 1'b0;
    lsu_req_i = 1'b1;
    lsu_we_i = 1'b0;
    lsu_size_i = 3'd2;
    lsu_addr_i = 32'h0;
    lsu_data_i = 32'h0;
    bus.data_gnt_i = 1'b0;
    bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chkZero("rst");
    @(posedge clk_i); #1;
    lsu_req_i = 1'b0;
    rstn_i = 1'b1;

    access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80AABBCC, 0, 0, 0);
    access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80AABBCC, 0, 0, 0);
    access(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 0);
    access(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0, 0);
    access(1'b0, 3'd1, 32'h203, 32'h0, 32'h0, 0, 0, 0);
    access(1'b0, 3'd5, 32'h306, 32'h0, 32'h8001F00D, 3, 1, 0);

    for (int t = 0; t < 40; t++)
      access(1'($urandom), 3'($urandom), $urandom, $urandom,
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1);

    // Reset during WAIT abandons the load; the late rvalid must be ignored.
    @(posedge clk_i); #1;
    lsu_req_i = 1'b1;
    lsu_we_i = 1'b0;
    lsu_size_i = 3'd2;
    lsu_addr_i = 32'h40;
    @(posedge clk_i); #1;
    bus.data_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus.data_gnt_i = 1'b0;
    rstn_i = 1'b0;
    @(negedge clk_i);
    chk("rstw_stall", {31'b0, lsu_stall_req_o}, 32'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    lsu_req_i = 1'b0;
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    chkZero("rstw");
    @(posedge clk_i); #1;
    bus.data_rvalid_i = 1'b0;
    @(negedge clk_i);
    chkZero("late");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
